// File: rtl/uc_multiciclo.sv
// Multicycle FETCH/EXEC control unit for the 16-bit I/O processor.
// Optional return-address stack enabled by defining UC_CALL_STACK_EN.
module uc_multiciclo #(
  parameter int PC_W        = 10,
  parameter int STACK_DEPTH = 4,
  parameter int N_IO        = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [5:0]      opcode,
  input  logic            z,
  input  logic [PC_W-1:0] pc_plus1,
  input  logic [N_IO-1:0] in_valid,
  output logic [2:0]      op,
  output logic            s_inc,
  output logic            s_inm,
  output logic            we3,
  output logic            s_r,
  output logic            s_mux5,
  output logic            s_rel,
  output logic [1:0]      s_e,
  output logic [N_IO-1:0] we_out,
  output logic [N_IO-1:0] in_ack,
  output logic            s_ret,
  output logic [PC_W-1:0] ret_addr,
  output logic            pc_en,
  output logic            fin,
  output logic            stk_ovf,
  output logic            stk_unf
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_WAIT_IN,
    S_HALT
  } state_t;

  state_t state_q, state_d;

  logic [1:0]      p;
  logic [N_IO-1:0] p_sel;
  logic            p_ok;
  logic            valid_p;
  logic            push;
  logic            pop;
  logic            stk_empty;

  assign p = opcode[5:4];

  // One-hot port select; ports beyond N_IO decode to all zeros
  always_comb begin
    p_sel = '0;
    for (int i = 0; i < N_IO; i++) begin
      p_sel[i] = (p == 2'(i));
    end
  end

  assign p_ok    = |p_sel;
  assign valid_p = |(in_valid & p_sel);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next state and datapath strobes
  always_comb begin
    state_d = state_q;
    op      = 3'b000;
    s_inc   = 1'b1;
    s_inm   = 1'b0;
    we3     = 1'b0;
    s_r     = 1'b0;
    s_mux5  = 1'b0;
    s_rel   = 1'b1;
    s_e     = 2'b00;
    we_out  = '0;
    in_ack  = '0;
    s_ret   = 1'b0;
    pc_en   = 1'b0;
    fin     = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        pc_en   = 1'b1;
        if (!opcode[3]) begin
          we3 = 1'b1;
          op  = opcode[2:0];
        end else begin
          case (opcode[2:0])
            3'b000: begin
              we3    = 1'b1;
              s_inm  = 1'b1;
              s_mux5 = 1'b1;
            end
            3'b001: begin
              case (p)
                2'b00: s_inc = 1'b0;
                2'b01: s_inc = ~z;
                2'b10: begin
                  s_inc = z;
                  op    = 3'b001;
                end
                default: ;
              endcase
            end
            3'b010: s_rel = 1'b0;
            3'b011: begin
`ifdef UC_CALL_STACK_EN
              s_inc = 1'b0;
              push  = 1'b1;
`endif
            end
            3'b100: we_out = p_sel;
            3'b101: begin
              we_out = p_sel;
              s_r    = p_ok;
            end
            3'b110: begin
              if (p_ok) begin
                s_e = p;
                if (valid_p) begin
                  we3    = 1'b1;
                  s_inm  = 1'b1;
                  in_ack = p_sel;
                end else begin
                  pc_en   = 1'b0;
                  state_d = S_WAIT_IN;
                end
              end
            end
            default: begin
              if (p == 2'b11) begin
                pc_en   = 1'b0;
                state_d = S_HALT;
              end else if (p == 2'b00) begin
`ifdef UC_CALL_STACK_EN
                pop   = 1'b1;
                s_ret = ~stk_empty;
`endif
              end
            end
          endcase
        end
      end
      S_WAIT_IN: begin
        s_e = p;
        if (valid_p) begin
          we3     = 1'b1;
          s_inm   = 1'b1;
          in_ack  = p_sel;
          pc_en   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_HALT: fin = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

`ifdef UC_CALL_STACK_EN
  localparam int AW   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  logic [PC_W-1:0] stk_q [STACK_DEPTH];
  logic [PC_W-1:0] stk_d [STACK_DEPTH];
  logic [SP_W-1:0] sp_q, sp_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            stk_full;
  logic [AW-1:0]   top_idx;
  logic [AW-1:0]   wr_idx;

  assign stk_empty = (sp_q == '0);
  assign stk_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign top_idx   = AW'(sp_q - SP_W'(1));
  assign wr_idx    = AW'(sp_q);
  assign ret_addr  = stk_empty ? '0 : stk_q[top_idx];
  assign stk_ovf   = ovf_q;
  assign stk_unf   = unf_q;

  // Push/pop bookkeeping; overflow drops the write, underflow falls through
  always_comb begin
    stk_d = stk_q;
    sp_d  = sp_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (push) begin
      if (stk_full) begin
        ovf_d = 1'b1;
      end else begin
        stk_d[wr_idx] = pc_plus1;
        sp_d          = sp_q + SP_W'(1);
      end
    end
    if (pop) begin
      if (stk_empty) unf_d = 1'b1;
      else           sp_d  = sp_q - SP_W'(1);
    end
  end

  // Stack storage, pointer and sticky error flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stk_q <= '{default: '0};
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      stk_q <= stk_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
`else
  logic unused_stk;

  assign stk_empty  = 1'b1;
  assign ret_addr   = '0;
  assign stk_ovf    = 1'b0;
  assign stk_unf    = 1'b0;
  assign unused_stk = ^{pc_plus1, push, pop, stk_empty};
`endif

endmodule

// File: tb/tb_uc_multiciclo.sv
// Directed table-driven bench for uc_multiciclo.
// Covers decode, input wait, halt, reset and (when built) the call stack.
module tb_uc_multiciclo;

  localparam int PC_W = 10;
`ifdef UC_CALL_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [5:0]      opcode;
  logic            z;
  logic [PC_W-1:0] pc_plus1;
  logic [3:0]      in_valid;
  logic [2:0]      op;
  logic            s_inc, s_inm, we3, s_r, s_mux5, s_rel;
  logic [1:0]      s_e;
  logic [3:0]      we_out, in_ack;
  logic            s_ret;
  logic [PC_W-1:0] ret_addr;
  logic            pc_en, fin, stk_ovf, stk_unf;

  logic [5:0]      opc2;
  logic [1:0]      iv2;
  logic [2:0]      op2;
  logic            s_inc2, s_inm2, we3_2, s_r2, s_mux5_2, s_rel2;
  logic [1:0]      s_e2;
  logic [1:0]      we_out2, in_ack2;
  logic            s_ret2;
  logic [PC_W-1:0] ret_addr2;
  logic            pc_en2, fin2, ovf2, unf2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uc_multiciclo #(.PC_W(PC_W), .STACK_DEPTH(4), .N_IO(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .z(z),
    .pc_plus1(pc_plus1), .in_valid(in_valid),
    .op(op), .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .s_r(s_r),
    .s_mux5(s_mux5), .s_rel(s_rel), .s_e(s_e), .we_out(we_out),
    .in_ack(in_ack), .s_ret(s_ret), .ret_addr(ret_addr),
    .pc_en(pc_en), .fin(fin), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  uc_multiciclo #(.PC_W(PC_W), .STACK_DEPTH(4), .N_IO(2)) dut2 (
    .clk(clk), .reset(reset), .opcode(opc2), .z(1'b0),
    .pc_plus1(pc_plus1), .in_valid(iv2),
    .op(op2), .s_inc(s_inc2), .s_inm(s_inm2), .we3(we3_2), .s_r(s_r2),
    .s_mux5(s_mux5_2), .s_rel(s_rel2), .s_e(s_e2), .we_out(we_out2),
    .in_ack(in_ack2), .s_ret(s_ret2), .ret_addr(ret_addr2),
    .pc_en(pc_en2), .fin(fin2), .stk_ovf(ovf2), .stk_unf(unf2)
  );

  typedef struct packed {
    logic [2:0] op;
    logic       s_inc, s_inm, we3, s_r, s_mux5, s_rel;
    logic [1:0] s_e;
    logic [3:0] we_out, in_ack;
    logic       s_ret, pc_en, fin;
  } outs_t;

  typedef struct {
    logic [5:0] opc;
    logic       z;
    logic [3:0] iv;
    outs_t      exp;
    string      name;
  } vec_t;

  function automatic outs_t mk(logic [2:0] o, logic inc, logic inm,
                               logic w3, logic sr, logic m5, logic rel,
                               logic [1:0] se, logic [3:0] wo,
                               logic [3:0] ia, logic ret);
    outs_t r;
    r.op = o; r.s_inc = inc; r.s_inm = inm; r.we3 = w3;
    r.s_r = sr; r.s_mux5 = m5; r.s_rel = rel; r.s_e = se;
    r.we_out = wo; r.in_ack = ia; r.s_ret = ret;
    r.pc_en = 1'b1; r.fin = 1'b0;
    return r;
  endfunction

  function automatic outs_t cur();
    outs_t r;
    r.op = op; r.s_inc = s_inc; r.s_inm = s_inm; r.we3 = we3;
    r.s_r = s_r; r.s_mux5 = s_mux5; r.s_rel = s_rel; r.s_e = s_e;
    r.we_out = we_out; r.in_ack = in_ack; r.s_ret = s_ret;
    r.pc_en = pc_en; r.fin = fin;
    return r;
  endfunction

  task automatic chk_outs(string nm, outs_t e);
    outs_t a;
    a = cur();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %b exp %b", nm, a, e);
    end
  endtask

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t  vecs[18];
  outs_t idle;

  initial begin
    idle       = mk(3'b0, 1, 0, 0, 0, 0, 1, 2'b0, 4'b0, 4'b0, 0);
    idle.pc_en = 1'b0;

    vecs[0]  = '{6'b000101, 1'b0, 4'b0000,
                 mk(3'd5, 1, 0, 1, 0, 0, 1, 2'd0, 4'b0, 4'b0, 0), "arith5"};
    vecs[1]  = '{6'b110010, 1'b1, 4'b0000,
                 mk(3'd2, 1, 0, 1, 0, 0, 1, 2'd0, 4'b0, 4'b0, 0), "arith2"};
    vecs[2]  = '{6'b011000, 1'b0, 4'b0000,
                 mk(3'd0, 1, 1, 1, 0, 1, 1, 2'd0, 4'b0, 4'b0, 0), "ldi"};
    vecs[3]  = '{6'b001001, 1'b0, 4'b0000,
                 mk(3'd0, 0, 0, 0, 0, 0, 1, 2'd0, 4'b0, 4'b0, 0), "jmp"};
    vecs[4]  = '{6'b011001, 1'b1, 4'b0000,
                 mk(3'd0, 0, 0, 0, 0, 0, 1, 2'd0, 4'b0, 4'b0, 0), "jz_z1"};
    vecs[5]  = '{6'b011001, 1'b0, 4'b0000,
                 mk(3'd0, 1, 0, 0, 0, 0, 1, 2'd0, 4'b0, 4'b0, 0), "jz_z0"};
    vecs[6]  = '{6'b101001, 1'b0, 4'b0000,
                 mk(3'd1, 0, 0, 0, 0, 0, 1, 2'd0, 4'b0, 4'b0, 0), "jnz_z0"};
    vecs[7]  = '{6'b101001, 1'b1, 4'b0000,
                 mk(3'd1, 1, 0, 0, 0, 0, 1, 2'd0, 4'b0, 4'b0, 0), "jnz_z1"};
    vecs[8]  = '{6'b111001, 1'b0, 4'b0000,
                 mk(3'd0, 1, 0, 0, 0, 0, 1, 2'd0, 4'b0, 4'b0, 0), "nop111001"};
    vecs[9]  = '{6'b001010, 1'b0, 4'b0000,
                 mk(3'd0, 1, 0, 0, 0, 0, 0, 2'd0, 4'b0, 4'b0, 0), "jrel"};
    vecs[10] = '{6'b101100, 1'b0, 4'b0000,
                 mk(3'd0, 1, 0, 0, 0, 0, 1, 2'd0, 4'b0100, 4'b0, 0), "out_p2"};
    vecs[11] = '{6'b111101, 1'b0, 4'b0000,
                 mk(3'd0, 1, 0, 0, 1, 0, 1, 2'd0, 4'b1000, 4'b0, 0), "outi_p3"};
    vecs[12] = '{6'b011110, 1'b0, 4'b0010,
                 mk(3'd0, 1, 1, 1, 0, 0, 1, 2'd1, 4'b0, 4'b0010, 0), "in_p1"};
    vecs[13] = '{6'b111110, 1'b0, 4'b1000,
                 mk(3'd0, 1, 1, 1, 0, 0, 1, 2'd3, 4'b0, 4'b1000, 0), "in_p3"};
    vecs[14] = '{6'b001011, 1'b0, 4'b0000,
                 mk(3'd0, !STK, 0, 0, 0, 0, 1, 2'd0, 4'b0, 4'b0, 0), "call"};
    vecs[15] = '{6'b011111, 1'b0, 4'b0000,
                 mk(3'd0, 1, 0, 0, 0, 0, 1, 2'd0, 4'b0, 4'b0, 0), "nop011111"};
    vecs[16] = '{6'b001111, 1'b0, 4'b0000,
                 mk(3'd0, 1, 0, 0, 0, 0, 1, 2'd0, 4'b0, 4'b0, STK), "ret"};
    vecs[17] = '{6'b001100, 1'b1, 4'b0000,
                 mk(3'd0, 1, 0, 0, 0, 0, 1, 2'd0, 4'b0001, 4'b0, 0), "out_p0"};

    reset    = 1'b0;
    opcode   = 6'b000000;
    z        = 1'b0;
    pc_plus1 = 10'd123;
    in_valid = 4'b0000;
    opc2     = 6'b000000;
    iv2      = 2'b00;

    step();
    step();
    chk_outs("reset_outs", idle);
    chk("reset_flags", {30'b0, stk_ovf, stk_unf}, 32'd0);
    chk("reset_ret_addr", 32'(ret_addr), 32'd0);
    reset = 1'b1;

    // Narrow instance: port 2 absent, port 1 present
    opc2 = 6'b101100;
    step();
    @(negedge clk);
    chk("n2_out_p2_we", {30'b0, we_out2}, 32'd0);
    chk("n2_out_p2_pc_en", {31'b0, pc_en2}, 32'd1);
    step();
    opc2 = 6'b011101;
    step();
    @(negedge clk);
    chk("n2_outi_p1", {29'b0, we_out2, s_r2}, {29'b0, 2'b10, 1'b1});
    step();
    opc2 = 6'b111110;
    iv2  = 2'b11;
    step();
    @(negedge clk);
    chk("n2_in_p3_nop", {28'b0, in_ack2, we3_2, pc_en2}, 32'd1);
    step();
    opc2 = 6'b000000;
    iv2  = 2'b00;

    for (int i = 0; i < 18; i++) begin
      opcode   = vecs[i].opc;
      z        = vecs[i].z;
      in_valid = vecs[i].iv;
      @(negedge clk);
      chk_outs({vecs[i].name, "_fetch"}, idle);
      step();
      @(negedge clk);
      chk_outs(vecs[i].name, vecs[i].exp);
      step();
    end
    chk("stack_idle_after_tbl", {20'b0, stk_ovf, stk_unf, ret_addr}, 32'd0);

    // Input wait: other ports valid must not release port 1
    opcode   = 6'b011110;
    z        = 1'b0;
    in_valid = 4'b1101;
    step();
    @(negedge clk);
    chk("in_exec_stall", {28'b0, pc_en, we3, s_e}, {28'b0, 2'b00, 2'b01});
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("in_wait", {24'b0, pc_en, we3, s_e, in_ack}, {24'b0, 4'b0001, 4'b0});
      step();
    end
    in_valid = 4'b0010;
    @(negedge clk);
    chk_outs("in_accept", mk(3'd0, 1, 1, 1, 0, 0, 1, 2'd1, 4'b0, 4'b0010, 0));
    step();
    @(negedge clk);
    chk("in_ack_once", {27'b0, in_ack, pc_en}, 32'd0);
    in_valid = 4'b0000;

`ifdef UC_CALL_STACK_EN
    for (int i = 0; i < 5; i++) begin
      opcode   = 6'b001011;
      pc_plus1 = 10'(10 * (i + 1));
      step();
      @(negedge clk);
      chk("call_exec", {30'b0, s_inc, pc_en}, 32'd1);
      step();
      chk("call_ovf", {31'b0, stk_ovf}, (i == 4) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 5; i++) begin
      opcode = 6'b001111;
      step();
      @(negedge clk);
      if (i < 4) begin
        chk("ret_addr", {21'b0, s_ret, ret_addr}, {21'b0, 1'b1, 10'(40 - 10 * i)});
      end else begin
        chk("ret_empty", {30'b0, s_ret, s_inc}, 32'd1);
      end
      step();
      chk("ret_unf", {31'b0, stk_unf}, (i == 4) ? 32'd1 : 32'd0);
    end
`endif

    // Reset in the middle of EXEC
    opcode = 6'b000001;
    step();
    #2;
    reset = 1'b0;
    #1;
    chk("rst_exec", {29'b0, pc_en, we3, fin}, 32'd0);
    chk("rst_stack", {20'b0, stk_ovf, stk_unf, ret_addr}, 32'd0);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_cad_fetch", {31'b0, pc_en}, 32'd0);
    step();
    @(negedge clk);
    chk("rst_cad_exec", {30'b0, pc_en, we3}, 32'd3);
    step();
    @(negedge clk);
    chk("rst_cad_fetch2", {31'b0, pc_en}, 32'd0);

    // Reset in the middle of WAIT_IN
    opcode   = 6'b101110;
    in_valid = 4'b0000;
    step();
    step();
    @(negedge clk);
    chk("wait_p2", {29'b0, pc_en, s_e}, 32'd2);
    reset = 1'b0;
    #1;
    chk("rst_wait", {29'b0, pc_en, s_e}, 32'd0);
    step();
    reset  = 1'b1;
    opcode = 6'b000000;
    step();
    @(negedge clk);
    chk("rst_wait_exec", {31'b0, pc_en}, 32'd1);
    step();

    // Halt
    opcode = 6'b111111;
    step();
    @(negedge clk);
    chk("halt_exec", {30'b0, fin, pc_en}, 32'd0);
    step();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("halt_hold", {30'b0, fin, pc_en}, 32'd2);
      step();
    end
    reset = 1'b0;
    #1;
    chk("halt_rst", {30'b0, fin, pc_en}, 32'd0);
    step();
    reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uc_multiciclo.md
# uc_multiciclo

Multicycle control unit for the 16-bit I/O processor. It replaces the single-cycle opcode decoder with a FETCH/EXEC state machine, and adds three things:
- a parametrised hardware return-address stack for subroutine call/return;
- a parametrised number of output/input ports;
- a valid/ack wait state on input reads.

It sits between the instruction memory/IR and the datapath (PC mux, register bank, ALU, I/O registers).

## Interface
Parameters:
- PC_W, 10, width of program-counter addresses.
- STACK_DEPTH, 4, return-address stack entries (power of two, 2..16).
- N_IO, 4, number of output and of input ports (1..4); port index is opcode[5:4].

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  6  IR opcode, stable from FETCH through the end of EXEC/WAIT_IN.
- z  in  1  ALU zero flag.
- pc_plus1  in  PC_W  address pushed on call.
- in_valid  in  N_IO  per-input-port data valid.
- op  out  3  ALU operation.
- s_inc, s_inm, we3, s_r, s_mux5, s_rel  out  1 each  datapath selects/enables, same meaning as the single-cycle unit.
- s_e  out  2  input port select.
- we_out  out  N_IO  one-hot output-register write enable.
- in_ack  out  N_IO  one-hot input consume strobe.
- s_ret  out  1  PC mux takes ret_addr.
- ret_addr  out  PC_W  stack top.
- pc_en  out  1  PC register load enable.
- fin  out  1  halted.
- stk_ovf, stk_unf  out  1 each  sticky stack error flags.

## Operation
- States: FETCH, EXEC, WAIT_IN, HALT.
- **FETCH**: all strobes 0 (s_rel=1, s_inc=1 as idle defaults); next state is EXEC.
- **EXEC**: decode opcode; assert strobes for one cycle with pc_en=1; next state is FETCH. Exceptions are listed below.
  - xx0xxx arithmetic: we3=1, op=opcode[2:0].
  - xx1000 load immediate: we3=1, s_inm=1, s_mux5=1.
  - 001001 absolute jump: s_inc=0.
  - 011001 jump if z: s_inc=~z.
  - 101001 jump if not z: s_inc=z, op=001.
  - xx1010 relative jump: s_rel=0.
  - xx1100 output register: we_out[p]=1, where p=opcode[5:4].
  - xx1101 output immediate: we_out[p]=1, s_r=1.
  - Ports with p ≥ N_IO: no we_out; the instruction behaves as a NOP.
  - xx1011 call: push pc_plus1; s_inc=0.
  - 001111 return: pop; s_ret=1.
  - xx1110 input: if in_valid[p], then we3=1, s_inm=1, s_e=p, in_ack[p]=1. Otherwise pc_en=0 and the next state is WAIT_IN.
  - 111111 halt: next state is HALT, pc_en=0.
  - All other codes (incl. 111001): NOP, s_inc=1.
- **WAIT_IN**: all strobes 0, pc_en=0, s_e=p held. Stay until in_valid[p]=1. In that cycle, assert the EXEC input strobes with pc_en=1, then go to FETCH.
- **HALT**: fin=1, pc_en=0, all strobes 0. Stays until reset.
- Stack: sp counts 0..STACK_DEPTH. ret_addr = entry[sp-1], or 0 when sp=0.
  - Push when full: no write, sp unchanged, stk_ovf←1, jump still taken.
  - Pop when empty: s_ret=0, s_inc=1 (fall through), stk_unf←1.
  - Flags clear only on reset.

## Timing
- Reset (async assert, sync-safe deassert):
  - state=FETCH, sp=0, flags=0, all entries 0.
  - Outputs at reset: strobes 0, s_inc=1, s_rel=1, fin=0, pc_en=0, s_ret=0.
- Outputs are combinational from state, opcode, z, in_valid and the stack top.
- Stack and flags update on the clk edge that ends EXEC (or the accepting WAIT_IN cycle).
- Latency: 2 cycles per instruction. Input adds the number of WAIT_IN cycles.
- in_ack is high exactly one cycle per accepted input.
- Reset mid-WAIT_IN or mid-HALT returns to FETCH and empties the stack.
- STACK_DEPTH consecutive calls fill the stack without error; the next call sets stk_ovf.
- z is sampled only in EXEC.

## Configuration
- UC_CALL_STACK_EN defined: call/return and the stack behave as above.
- UC_CALL_STACK_EN undefined: no stack storage; xx1011 and 001111 decode as NOP. s_ret, ret_addr, stk_ovf and stk_unf are tied to 0.

## Test plan
- Reset low mid-EXEC → state FETCH, sp=0, fin=0, pc_en=0; release → 2-cycle instruction cadence resumes.
- Opcode 011001 with z=1, then z=0 → EXEC s_inc=0 then s_inc=1; op=000 both times.
- Input opcode 011110 with in_valid=0 for 3 cycles, then in_valid[1]=1 → 3 WAIT_IN cycles with pc_en=0, s_e=01. Then one cycle with we3=1 and in_ack=0010.
- STACK_DEPTH=4: calls with pc_plus1=10,20,30,40,50 → 5th sets stk_ovf=1. Then returns → ret_addr 40,30,20,10; the 5th return sets stk_unf=1 and s_inc=1.
- N_IO=2, opcode 101100 → we_out=00; opcode 011101 → we_out=10, s_r=1.
- Opcode 111111 → fin=1 held for 20 cycles with pc_en=0; reset clears it.
